// File: rtl/kmer_pkg.sv
// Shared types and sizing for the k-mer front end and the downstream
// minhash/Jaccard stage that consumes the packed k-mer array.
package kmer_pkg;

   localparam int K         = 16;
   localparam int READ_LEN  = 64;
   localparam int KMER_W    = 2 * K;
   localparam int NUM_KMERS = READ_LEN - K + 1;
   localparam int CNT_W     = $clog2(READ_LEN + 1);
   localparam int IDX_W     = $clog2(NUM_KMERS);

   typedef enum logic [1:0] {
      BASE_A = 2'b00,
      BASE_C = 2'b01,
      BASE_G = 2'b10,
      BASE_T = 2'b11
   } base_t;

   typedef logic [KMER_W-1:0] kmer_t;

   typedef kmer_t [NUM_KMERS-1:0] kmer_arr_t;

   typedef enum logic [1:0] {
      FILL,
      DISCARD,
      DONE
   } state_t;

endpackage

// File: rtl/kmer_extractor.sv
// Streams one 2-bit base per cycle into a sliding window and stores every
// overlapping K-mer of a fixed-length read. The full array is then held for
// the downstream stage until it acknowledges. Reads of the wrong length
// produce a single-cycle lenErr pulse and are dropped.
module kmer_extractor
   import kmer_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            baseValid,
   input  logic [1:0]      baseIn,
   input  logic            baseLast,
   output logic            baseReady,
   output kmer_arr_t       kmersOut,
   output logic            kmersValid,
   input  logic            kmersAck,
   output logic            lenErr
);

   state_t                 state_q,   state_d;
   logic [CNT_W-1:0]       baseCnt_q, baseCnt_d;
   kmer_t                  window_q,  window_d;
   kmer_arr_t              kmers_q,   kmers_d;
   logic                   lenErr_q,  lenErr_d;

   logic                   accept;
   kmer_t                  newKmer;
   logic [IDX_W-1:0]       writeIdx;

   // The block takes bases whenever it is not holding a finished read, and
   // never while reset is asserted.
   assign baseReady  = !rst && (state_q != DONE);
   assign accept     = baseValid && baseReady;
   assign kmersValid = (state_q == DONE);
   assign kmersOut   = kmers_q;
   assign lenErr     = lenErr_q;

   // The incoming base completes the K-mer ending at the current count; the
   // earliest base of that K-mer ends up in the MSBs.
   assign newKmer  = {window_q[KMER_W-3:0], baseIn};
   assign writeIdx = IDX_W'(baseCnt_q - CNT_W'(K - 1));

   // Next-state logic: window shift, k-mer capture, length checking and the
   // hand-off to the downstream stage.
   always_comb begin
      state_d   = state_q;
      baseCnt_d = baseCnt_q;
      window_d  = window_q;
      kmers_d   = kmers_q;
      lenErr_d  = 1'b0;

      case (state_q)
         FILL: begin
            if (accept) begin
               window_d  = newKmer;
               baseCnt_d = baseCnt_q + CNT_W'(1);
               if (baseCnt_q >= CNT_W'(K - 1)) begin
                  kmers_d[writeIdx] = newKmer;
               end
               if (baseLast) begin
                  if (baseCnt_q == CNT_W'(READ_LEN - 1)) begin
                     state_d = DONE;
                  end else begin
                     lenErr_d  = 1'b1;
                     baseCnt_d = '0;
                     window_d  = '0;
                  end
               end else if (baseCnt_q == CNT_W'(READ_LEN - 1)) begin
                  state_d = DISCARD;
               end
            end
         end

         DISCARD: begin
            if (accept && baseLast) begin
               lenErr_d  = 1'b1;
               baseCnt_d = '0;
               window_d  = '0;
               state_d   = FILL;
            end
         end

         DONE: begin
            if (kmersAck) begin
               baseCnt_d = '0;
               window_d  = '0;
               state_d   = FILL;
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State register with synchronous reset; reset drops any partial read
   // silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         baseCnt_q <= '0;
         window_q  <= '0;
         kmers_q   <= '0;
         lenErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         baseCnt_q <= baseCnt_d;
         window_q  <= window_d;
         kmers_q   <= kmers_d;
         lenErr_q  <= lenErr_d;
      end
   end

endmodule

// File: tb/tb_kmer_extractor.sv
// Self-checking bench for kmer_extractor: directed reads from the test plan
// plus randomized reads with random gaps, checked against a reference model
// that rebuilds each k-mer arithmetically from the list of bases sent.
module tb_kmer_extractor;
   import kmer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baseValid = 1'b0;
   logic [1:0] baseIn = 2'b00;
   logic       baseLast = 1'b0;
   logic       baseReady;
   kmer_arr_t  kmersOut;
   logic       kmersValid;
   logic       kmersAck = 1'b0;
   logic       lenErr;

   int          checkCount = 0;
   int          passCount  = 0;
   int unsigned refBases [0:127];
   int          lastWait;

   kmer_extractor dut (
      .clk        (clk),
      .rst        (rst),
      .baseValid  (baseValid),
      .baseIn     (baseIn),
      .baseLast   (baseLast),
      .baseReady  (baseReady),
      .kmersOut   (kmersOut),
      .kmersValid (kmersValid),
      .kmersAck   (kmersAck),
      .lenErr     (lenErr)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference k-mer i: bases i..i+K-1 read as a base-4 number, earliest
   // base most significant.
   function automatic int unsigned refKmer(input int i);
      int unsigned v;
      v = 0;
      for (int j = 0; j < K; j++) begin
         v = v * 4 + refBases[i + j];
      end
      return v;
   endfunction

   // Offer one base until it is taken; called at posedge+1, returns at
   // posedge+1 after the accepting edge.
   task automatic applyStimulus(input int unsigned b, input logic last);
      bit accepted;
      int waited;
      accepted  = 1'b0;
      waited    = 0;
      baseValid = 1'b1;
      baseIn    = 2'(b);
      baseLast  = last;
      while (!accepted) begin
         @(negedge clk);
         if (baseReady) begin
            checkOutput("validDuringRead", 64'(kmersValid), 64'd0);
            accepted = 1'b1;
         end else if (waited >= 200) begin
            checkOutput("readyTimeout", 64'(0), 64'(1));
            accepted = 1'b1;
         end
         waited++;
         @(posedge clk);
         #1;
      end
      lastWait  = waited - 1;
      baseValid = 1'b0;
      baseLast  = 1'b0;
   endtask

   // Send one read of len bases; mode 0 random, 1 all T, 2 j mod 4,
   // 3 all A, 4 all G. Then check the outcome predicted by the model.
   task automatic runRead(input int len, input int mode, input int maxGap);
      bit expValid;
      int totalWait;
      totalWait = 0;
      for (int j = 0; j < len; j++) begin
         case (mode)
            1:       refBases[j] = 3;
            2:       refBases[j] = j % 4;
            3:       refBases[j] = 0;
            4:       refBases[j] = 2;
            default: refBases[j] = $urandom_range(0, 3);
         endcase
      end
      for (int j = 0; j < len; j++) begin
         int gap;
         gap = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(refBases[j], j == len - 1);
         totalWait += lastWait;
      end
      expValid = (len == READ_LEN);
      if (len > READ_LEN) begin
         checkOutput("readyDuringLong", 64'(totalWait), 64'd0);
      end
      @(negedge clk);
      checkOutput("lenErr", 64'(lenErr), 64'(!expValid));
      checkOutput("kmersValid", 64'(kmersValid), 64'(expValid));
      if (expValid) begin
         checkOutput("readyInDone", 64'(baseReady), 64'd0);
         for (int i = 0; i < NUM_KMERS; i++) begin
            checkOutput($sformatf("kmer%0d", i), 64'(kmersOut[i]), 64'(refKmer(i)));
         end
         // Hold the result with bases offered and no ack.
         for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            baseValid = 1'b1;
            baseIn    = 2'($urandom_range(0, 3));
            @(negedge clk);
            checkOutput("holdReady", 64'(baseReady), 64'd0);
            checkOutput("holdValid", 64'(kmersValid), 64'd1);
            checkOutput("holdKmer0", 64'(kmersOut[0]), 64'(refKmer(0)));
            checkOutput("holdKmer48", 64'(kmersOut[NUM_KMERS-1]), 64'(refKmer(NUM_KMERS-1)));
         end
         baseValid = 1'b0;
         kmersAck  = 1'b1;
         @(posedge clk);
         #1;
         kmersAck = 1'b0;
         @(negedge clk);
         checkOutput("validAfterAck", 64'(kmersValid), 64'd0);
         checkOutput("readyAfterAck", 64'(baseReady), 64'd1);
         checkOutput("lenErrAfterAck", 64'(lenErr), 64'd0);
      end else begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("lenErrOneCycle", 64'(lenErr), 64'd0);
         checkOutput("validAfterBad", 64'(kmersValid), 64'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstReady", 64'(baseReady), 64'd0);
      checkOutput("rstValid", 64'(kmersValid), 64'd0);
      checkOutput("rstLenErr", 64'(lenErr), 64'd0);
      checkOutput("rstKmer0", 64'(kmersOut[0]), 64'd0);
      checkOutput("rstKmer48", 64'(kmersOut[NUM_KMERS-1]), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed reads.
      runRead(64, 1, 0);
      checkOutput("allT", 64'(kmersOut[7]), 64'h0000_0000_FFFF_FFFF);
      runRead(64, 2, 0);
      checkOutput("mod4k0", 64'(kmersOut[0]), 64'h1B1B_1B1B);
      checkOutput("mod4k1", 64'(kmersOut[1]), 64'h6C6C_6C6C);
      checkOutput("mod4k48", 64'(kmersOut[48]), 64'h1B1B_1B1B);
      runRead(20, 3, 0);
      runRead(64, 3, 0);
      checkOutput("allA", 64'(kmersOut[20]), 64'd0);
      runRead(70, 0, 0);

      // Reset in the middle of a read, then a clean read of G.
      for (int j = 0; j < 31; j++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         applyStimulus($urandom_range(0, 3), 1'b0);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRstReady", 64'(baseReady), 64'd0);
      checkOutput("midRstLenErr", 64'(lenErr), 64'd0);
      checkOutput("midRstKmer0", 64'(kmersOut[0]), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      runRead(64, 4, 2);
      checkOutput("allG", 64'(kmersOut[33]), 64'hAAAA_AAAA);

      // Randomized reads of mixed lengths with random gaps.
      for (int r = 0; r < 12; r++) begin
         int pick;
         int len;
         pick = $urandom_range(0, 3);
         if (pick == 0) begin
            len = $urandom_range(1, READ_LEN - 1);
         end else if (pick == 3) begin
            len = $urandom_range(READ_LEN + 1, 80);
         end else begin
            len = READ_LEN;
         end
         runRead(len, 0, 2);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
